// File: rtl/adc_acq_ctrl.sv
// ADC acquisition controller: optional level trigger, 1-of-(N+1) decimation,
// fixed-length capture delivered over a valid/ready output register.
module adc_acq_ctrl #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              SYS_CLK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] SMP_DATA,
  input  logic              SMP_VALID,
  input  logic [CNT_W-1:0]  CFG_LEN,
  input  logic [3:0]        CFG_DECIM,
  input  logic              CFG_TRIG_MODE,
  input  logic [DATA_W-1:0] CFG_THRESH,
  input  logic              START,
  input  logic              ABORT,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              OUT_LAST,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVERFLOW
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_TRIG = 2'd1;
  localparam logic [1:0] CAPTURE   = 2'd2;
  localparam logic [1:0] DRAIN     = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  len_q, smp_cnt, cnt_nxt;
  logic [3:0]        decim_q, dec_cnt;
  logic [DATA_W-1:0] thresh_q;
  logic              trig_hit, proc, keep, can_load, load, last_load, hs;

  // Sample qualification: the trigger sample itself counts as the first capture sample.
  always_comb begin
    trig_hit  = SMP_VALID && (SMP_DATA >= thresh_q);
    proc      = ((state == CAPTURE) && SMP_VALID) || ((state == WAIT_TRIG) && trig_hit);
    keep      = proc && (dec_cnt == 4'd0);
    can_load  = !OUT_VALID || OUT_READY;
    load      = keep && can_load;
    cnt_nxt   = smp_cnt + CNT_W'(1);
    last_load = load && (cnt_nxt == len_q);
    hs        = OUT_VALID && OUT_READY;
  end

  assign BUSY = (state != IDLE);

  // Control FSM, config latch, counters and output register.
  always_ff @(posedge SYS_CLK) begin
    if (!RESET_N) begin
      state    <= IDLE;
      len_q    <= '0;
      decim_q  <= '0;
      thresh_q <= '0;
      smp_cnt  <= '0;
      dec_cnt  <= '0;
      OUT_DATA  <= '0;
      OUT_VALID <= 1'b0;
      OUT_LAST  <= 1'b0;
      DONE      <= 1'b0;
      OVERFLOW  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          // ABORT in the same cycle suppresses the start.
          if (START && !ABORT && (CFG_LEN != '0)) begin
            len_q    <= CFG_LEN;
            decim_q  <= CFG_DECIM;
            thresh_q <= CFG_THRESH;
            smp_cnt  <= '0;
            dec_cnt  <= '0;
            OVERFLOW <= 1'b0;
            state    <= CFG_TRIG_MODE ? WAIT_TRIG : CAPTURE;
          end
        end
        default: begin
          if (ABORT) begin
            state     <= IDLE;
            OUT_VALID <= 1'b0;
            OUT_LAST  <= 1'b0;
          end else begin
            // Decimation phase advances on every processed sample, kept or dropped.
            if (proc)
              dec_cnt <= (dec_cnt == decim_q) ? 4'd0 : dec_cnt + 4'd1;
            if (load) begin
              OUT_DATA  <= SMP_DATA;
              OUT_VALID <= 1'b1;
              OUT_LAST  <= last_load;
              smp_cnt   <= cnt_nxt;
            end else if (hs) begin
              OUT_VALID <= 1'b0;
              OUT_LAST  <= 1'b0;
            end
            if (keep && !can_load)
              OVERFLOW <= 1'b1;
            // In DRAIN no loads happen, so the pending beat is the last one.
            if ((state == DRAIN) && hs) begin
              state <= IDLE;
              DONE  <= 1'b1;
            end else if (last_load) begin
              state <= DRAIN;
            end else if ((state == WAIT_TRIG) && trig_hit) begin
              state <= CAPTURE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/adc_acq_ctrl.md
ADC_ACQ_CTRL -- requirements
Module: adc_acq_ctrl

Interface
REQ-001 Parameter DATA_W, default 10, ADC sample width.
REQ-002 Parameter CNT_W, default 16, capture-length counter width.
REQ-003 The block SHALL have a single clock; reset is synchronous and active-low.
REQ-004 Port SYS_CLK  in  1  system clock; all logic on its rising edge.
REQ-005 Port RESET_N  in  1  synchronous active-low reset.
REQ-006 Port SMP_DATA  in  DATA_W  captured ADC sample, already in the SYS_CLK domain.
REQ-007 Port SMP_VALID  in  1  SMP_DATA valid this cycle.
REQ-008 Port CFG_LEN  in  CNT_W  samples to deliver per capture.
REQ-009 Port CFG_DECIM  in  4  keep one of every CFG_DECIM+1 valid samples.
REQ-010 Port CFG_TRIG_MODE  in  1  0 = immediate start; 1 = level trigger.
REQ-011 Port CFG_THRESH  in  DATA_W  unsigned trigger threshold.
REQ-012 Port START  in  1  one-cycle capture request.
REQ-013 Port ABORT  in  1  one-cycle cancel request.
REQ-014 Port OUT_DATA  out  DATA_W  delivered sample.
REQ-015 Port OUT_VALID  out  1  OUT_DATA valid; held until accepted.
REQ-016 Port OUT_READY  in  1  consumer accepts when OUT_VALID&&OUT_READY.
REQ-017 Port OUT_LAST  out  1  marks final sample of a capture.
REQ-018 Port BUSY  out  1  capture in progress.
REQ-019 Port DONE  out  1  one-cycle pulse on normal completion.
REQ-020 Port OVERFLOW  out  1  sticky: at least one kept sample dropped.

Function
REQ-021 FSM states SHALL be IDLE, WAIT_TRIG, CAPTURE, DRAIN; BUSY=1 in all but IDLE.
REQ-022 IDLE: START with CFG_LEN!=0 latches all CFG_* inputs, clears OVERFLOW, sample counter and decimation counter; next state WAIT_TRIG if CFG_TRIG_MODE=1, else CAPTURE.
REQ-023 START with CFG_LEN=0, or START outside IDLE, SHALL be ignored.
REQ-024 WAIT_TRIG: first SMP_VALID sample with SMP_DATA>=latched threshold is the trigger; it is processed as the first CAPTURE sample in that same cycle; state becomes CAPTURE.
REQ-025 CAPTURE: each SMP_VALID sample is kept when dec_cnt==0; dec_cnt increments per valid sample, wraps to 0 after reaching latched CFG_DECIM.
REQ-026 Kept sample SHALL load the output register when OUT_VALID==0 or OUT_READY==1 (same-cycle replace); OUT_VALID rises the cycle after (latency 1).
REQ-027 Kept sample arriving while OUT_VALID=1 and OUT_READY=0 SHALL be dropped, set OVERFLOW, not increment the sample counter.
REQ-028 Sample counter increments per loaded sample; the load making count==CFG_LEN sets OUT_LAST with it; state becomes DRAIN; further samples ignored.
REQ-029 DRAIN: on handshake of the OUT_LAST sample, DONE pulses for one cycle in the following cycle, which is IDLE.
REQ-030 OUT_DATA/OUT_LAST SHALL stay stable while OUT_VALID=1 and OUT_READY=0.
REQ-031 ABORT in any non-IDLE state: next cycle IDLE, OUT_VALID=0, OUT_LAST=0, no DONE; OVERFLOW retained. ABORT with START same cycle: ABORT wins, no capture begins.
REQ-032 Counter comparisons unsigned, CNT_W wide; CFG_LEN max value (2^CNT_W-1) SHALL complete without wrap.
REQ-033 CFG_* changes after START SHALL not affect a running capture.

Reset
REQ-034 RESET_N=0 at a clock edge: state IDLE; OUT_DATA=0, OUT_VALID=0, OUT_LAST=0, BUSY=0, DONE=0, OVERFLOW=0, all counters 0; reset mid-capture abandons it with no DONE.

Verification
REQ-035 Immediate: LEN=4, DECIM=0, OUT_READY=1, SMP_VALID every cycle with 1,2,3,4,5 -> OUT_DATA 1..4 each one cycle later, OUT_LAST with 4, DONE one cycle after that handshake, BUSY then 0.
REQ-036 Decimation: LEN=3, DECIM=2, samples 10..18 continuous -> delivered 10,13,16; OUT_LAST on 16.
REQ-037 Trigger: MODE=1, THRESH=0x200, samples 0x100,0x1FF,0x200,0x300 with LEN=2 -> delivered 0x200,0x300; nothing before 0x200.
REQ-038 Backpressure: LEN=3, OUT_READY=0 for 3 cycles after first load, samples 1..6 continuous -> OUT_DATA held at 1, 2 and 3 dropped, OVERFLOW=1, delivered 1,4,5 with OUT_LAST on 5.
REQ-039 Abort/reset: ABORT after 2 of LEN=8 delivered -> OUT_VALID=0 and BUSY=0 next cycle, no DONE; repeat with RESET_N=0 mid-capture -> all outputs at reset values.
REQ-040 Ignored START: START during CAPTURE and START with CFG_LEN=0 in IDLE -> no state or config change.
